// File: rtl/stack_unit.sv
// Stack sequencer for MiniRISC: two-byte push/pop frames with SP ownership,
// return-value capture and sticky overflow/underflow detection.
module stack_unit #(
    parameter logic [7:0] SP_INIT      = 8'hFF,
    parameter logic [7:0] STACK_BOTTOM = 8'hE0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       initialize,
    input  logic       stack_op_ongoing,
    input  logic       push_or_pop,
    input  logic       bus_grant,
    input  logic [7:0] pc_in,
    input  logic [5:0] flags_in,
    input  logic [7:0] mem_din,
    output logic [7:0] stack_addr,
    output logic [7:0] stack_dout,
    output logic       stack_op_end,
    output logic [7:0] ret_pc,
    output logic [5:0] ret_flags,
    output logic [7:0] sp,
    output logic       stack_ovf,
    output logic       stack_unf
);

    localparam logic PUSH = 1'b0;
    localparam logic POP  = 1'b1;

    logic [7:0] sp_q;
    logic       phase_q;
    logic       dir_q;
    logic       err_q;
    logic [7:0] ret_pc_q;
    logic [5:0] ret_flags_q;
    logic       ovf_q;
    logic       unf_q;

    logic       dir;
    logic       is_pop;
    logic [7:0] sp_inc;
    logic [7:0] sp_dec;
    logic       err_now;
    logic       err;

    // Phase 1 uses the direction and error latched at the phase 0 grant.
    always_comb begin
        dir     = phase_q ? dir_q : push_or_pop;
        is_pop  = (dir == POP);
        sp_inc  = sp_q + 8'd1;
        sp_dec  = sp_q - 8'd1;
        err_now = is_pop ? (sp_q > (SP_INIT - 8'd2)) : (sp_q < (STACK_BOTTOM + 8'd1));
        err     = phase_q ? err_q : err_now;
    end

    always_comb begin
        stack_addr   = sp_q;
        stack_dout   = pc_in;
        stack_op_end = 1'b0;
        if (stack_op_ongoing) begin
            if (is_pop) begin
                stack_addr = sp_inc;
            end
            if (phase_q && !is_pop) begin
                stack_dout = {2'b00, flags_in};
            end
            stack_op_end = bus_grant & phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q        <= SP_INIT;
            phase_q     <= 1'b0;
            dir_q       <= PUSH;
            err_q       <= 1'b0;
            ret_pc_q    <= 8'h00;
            ret_flags_q <= 6'h00;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (initialize) begin
            sp_q        <= SP_INIT;
            phase_q     <= 1'b0;
            dir_q       <= PUSH;
            err_q       <= 1'b0;
            ret_pc_q    <= 8'h00;
            ret_flags_q <= 6'h00;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (!stack_op_ongoing) begin
            phase_q <= 1'b0;
        end else if (bus_grant) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                dir_q <= push_or_pop;
                err_q <= err_now;
            end
            if (err) begin
                // Errored frame: SP and return registers stay put.
                if (is_pop) begin
                    unf_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else begin
                sp_q <= is_pop ? sp_inc : sp_dec;
                if (is_pop) begin
                    if (phase_q) begin
                        ret_pc_q <= mem_din;
                    end else begin
                        ret_flags_q <= mem_din[5:0];
                    end
                end
            end
        end
    end

    assign sp        = sp_q;
    assign ret_pc    = ret_pc_q;
    assign ret_flags = ret_flags_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: doc/stack_unit.md
# stack_unit

Stack sequencer for the MiniRISC CPU v2.0. It services the controller FSM's stack operations: JSR and interrupt entry push two bytes, RTS and RTI pop them. It owns the stack pointer (SP), supplies address and write data for each stack access, captures the popped return address and flags, and reports completion back to the controller with `stack_op_end`. The controller drives `data_mem_wr`/`data_mem_rd` itself; this block only sequences the accesses and advances SP.

## Interface
- `SP_INIT`, 8'hFF: SP value after reset/initialize; empty-stack top address.
- `STACK_BOTTOM`, 8'hE0: lowest address the stack may occupy.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `initialize`  in  1  synchronous re-init from controller; same effect as reset, except that outputs update on the clock edge.
- `stack_op_ongoing`  in  1  controller is in its stack-operation state.
- `push_or_pop`  in  1  direction of the operation, using the PUSH/POP codes from `control_defs.vh`.
- `bus_grant`  in  1  current data-memory access is granted this cycle.
- `pc_in`  in  8  return address to push.
- `flags_in`  in  6  flags to push, packed {IF,IE,V,N,C,Z}.
- `mem_din`  in  8  read data; valid in the granted cycle.
- `stack_addr`  out  8  data-memory address for the current stack access.
- `stack_dout`  out  8  write data for the current push access.
- `stack_op_end`  out  1  last access granted this cycle (Mealy).
- `ret_pc`  out  8  popped PC (registered).
- `ret_flags`  out  6  popped flags (registered).
- `sp`  out  8  current stack pointer (debug/observability).
- `stack_ovf`  out  1  sticky push-overflow error.
- `stack_unf`  out  1  sticky pop-underflow error.

## Operation
- State: SP register, a 1-bit `phase` (0 = first byte, 1 = second byte), and a 1-bit registered error qualifier for the current operation.
- A frame is 2 bytes. PC sits at the higher address and flags at the lower. The stack grows downward; SP points at the next free byte.
- PUSH, phase 0:
  - `stack_addr`=SP, `stack_dout`=`pc_in`.
  - On grant: SP←SP−1, phase←1.
- PUSH, phase 1:
  - `stack_addr`=SP, `stack_dout`={2'b00,`flags_in`}.
  - On grant: SP←SP−1, phase←0, `stack_op_end`=1.
- POP, phase 0:
  - `stack_addr`=SP+1.
  - On grant: `ret_flags`←`mem_din[5:0]`, SP←SP+1, phase←1.
- POP, phase 1:
  - `stack_addr`=SP+1.
  - On grant: `ret_pc`←`mem_din`, SP←SP+1, phase←0, `stack_op_end`=1.
- While `stack_op_ongoing`=0: phase is held at 0, SP is held, `stack_op_end`=0, and `stack_addr`=SP.
- No grant means the block holds all state; it may wait any number of cycles.
- SP arithmetic is 8-bit modulo.
- Overflow:
  - Detected at phase 0 of a PUSH when SP < STACK_BOTTOM+1 (fewer than 2 free bytes).
  - `stack_ovf`←1 (sticky); SP is held for both phases of that operation.
  - Addresses are still driven and the controller still writes (both bytes land at SP).
  - `stack_op_end` behaves normally, so the controller never hangs.
- Underflow:
  - Detected at phase 0 of a POP when SP > SP_INIT−2 (fewer than 2 bytes stacked).
  - `stack_unf`←1 (sticky); SP is held; `ret_pc`/`ret_flags` are not updated.
  - `stack_op_end` behaves normally.
- `stack_ovf`/`stack_unf` are cleared only by reset or `initialize`.
- Both `push_or_pop` and the error qualifier are latched at phase 0 grant and used for phase 1. A change of `push_or_pop` mid-frame is ignored.

## Timing
- Reset (`rst_n`=0, asynchronous) sets: SP=SP_INIT, phase=0, `ret_pc`=0, `ret_flags`=0, `stack_ovf`=0, `stack_unf`=0.
- Combinational outputs in reset: `stack_op_end`=0, `stack_addr`=SP_INIT, `stack_dout`=`pc_in`.
- `initialize`=1 at a clock edge applies the same values synchronously and takes priority over any access.
- `stack_addr`, `stack_dout` and `stack_op_end` are combinational from state plus `push_or_pop`/`bus_grant`. They are valid in the same cycle `stack_op_ongoing` first rises; there is no idle cycle before the first access.
- Minimum latency is 2 cycles (grant in both cycles). `stack_op_end` is high in the second granted cycle, and the controller leaves its stack state on that edge.
- `stack_op_end` is never high for more than one cycle per frame.
- `ret_pc`/`ret_flags` are valid from the edge that ends the frame onward and hold until the next successful pop.
- Reset mid-frame: the frame is abandoned, phase=0, and SP returns to SP_INIT.
- `stack_op_ongoing` dropping mid-frame (phase 1) forces phase←0 at the next edge. SP keeps its single decrement/increment; no further action.

## Test plan
- Reset, then JSR push with `pc_in`=8'h42, `flags_in`=6'h15, grant every cycle:
  - cycle 0 writes 8'h42 @FF; cycle 1 writes 8'h15 @FE with `stack_op_end`=1; SP=FD.
- Pop after that push, memory returning 8'h15 then 8'h42:
  - reads @FE then @FF; `ret_flags`=6'h15, `ret_pc`=8'h42; SP=FF; end pulse in the 2nd cycle.
- Push with `bus_grant` low for 3 cycles before each byte:
  - SP and `stack_addr` stable while waiting; `stack_op_end` only in the final granted cycle; total 8 cycles.
- 16 pushes from reset fill E0..FF (SP=DF); the 17th push:
  - `stack_ovf`=1, SP stays DF, end pulse still produced; `initialize` clears it and sets SP=FF.
- Pop from empty stack (SP=FF):
  - `stack_unf`=1, SP=FF, `ret_pc`/`ret_flags` unchanged, end pulse produced.
- `rst_n` low during phase 1 of a push:
  - SP=FF, phase 0, and the next push starts at FF.
